// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage controller for the 16-bit PC register.
// Drives the PC register's D input and write enable from the current PC,
// runs the instruction-memory handshake, and loads the IF/ID pipeline register.
//
//   state       | meaning
//   ------------+----------------------------------------------------------
//   RESET_LOAD  | first cycle after reset release, writes RESET_PC
//   FETCH       | fetch request active, accept on imem_ready
//   MISS_WAIT   | imem not ready, hold address and insert bubbles
//   HALT        | HALT accepted, fetch frozen until redirect or reset
module pc_fetch_ctrl #(
  parameter int              ADDR_W      = 16,
  parameter int              INSTR_W     = 16,
  parameter logic [15:0]     RESET_PC    = 16'h0000,
  parameter int              PC_INC      = 2,
  parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc_q,
  output logic [ADDR_W-1:0]  pc_d,
  output logic               pc_we,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_ready,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc_plus,
  output logic               ifid_valid,
  output logic               halted
);

  localparam logic [1:0] S_RESET_LOAD = 2'd0;
  localparam logic [1:0] S_FETCH      = 2'd1;
  localparam logic [1:0] S_MISS_WAIT  = 2'd2;
  localparam logic [1:0] S_HALT       = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [INSTR_W-1:0] ifid_instr_q, ifid_instr_d;
  logic [ADDR_W-1:0]  ifid_pc_plus_q, ifid_pc_plus_d;
  logic               ifid_valid_q, ifid_valid_d;
  logic               halted_q, halted_d;
  logic [ADDR_W-1:0]  pc_inc;
  logic               is_halt;

  // Sequential PC wraps modulo 2^ADDR_W; the fetch address is always the live PC.
  assign pc_inc    = pc_q + ADDR_W'(PC_INC);
  assign is_halt   = (imem_rdata[INSTR_W-1 -: 4] == HALT_OPCODE);
  assign imem_addr = pc_q;

  // Next-state, PC write and IF/ID update selection; reset forces the PC-side outputs quiet.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    pc_we          = 1'b0;
    imem_req       = 1'b0;
    ifid_instr_d   = ifid_instr_q;
    ifid_pc_plus_d = ifid_pc_plus_q;
    ifid_valid_d   = ifid_valid_q;
    halted_d       = halted_q;
    case (state_q)
      S_RESET_LOAD: begin
        pc_d    = ADDR_W'(RESET_PC);
        pc_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_FETCH, S_MISS_WAIT: begin
        imem_req = 1'b1;
        if (br_taken) begin
          pc_d         = br_target;
          pc_we        = 1'b1;
          ifid_valid_d = 1'b0;
          state_d      = S_FETCH;
        end else if (stall) begin
          // hold PC and IF/ID, stay in the current fetch state
        end else if (!imem_ready) begin
          ifid_valid_d = 1'b0;
          state_d      = S_MISS_WAIT;
        end else begin
          ifid_instr_d   = imem_rdata;
          ifid_pc_plus_d = pc_inc;
          ifid_valid_d   = 1'b1;
          if (is_halt) begin
            // PC is left pointing at the HALT so a restart re-fetches it
            halted_d = 1'b1;
            state_d  = S_HALT;
          end else begin
            pc_d    = pc_inc;
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_HALT: begin
        if (br_taken) begin
          pc_d         = br_target;
          pc_we        = 1'b1;
          halted_d     = 1'b0;
          ifid_valid_d = 1'b0;
          state_d      = S_FETCH;
        end else if (!stall) begin
          ifid_valid_d = 1'b0;
        end
      end
      default: state_d = S_RESET_LOAD;
    endcase
    if (!rst) begin
      pc_d     = '0;
      pc_we    = 1'b0;
      imem_req = 1'b0;
    end
  end

  // State and IF/ID registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q        <= S_RESET_LOAD;
      ifid_instr_q   <= '0;
      ifid_pc_plus_q <= '0;
      ifid_valid_q   <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      ifid_instr_q   <= ifid_instr_d;
      ifid_pc_plus_q <= ifid_pc_plus_d;
      ifid_valid_q   <= ifid_valid_d;
      halted_q       <= halted_d;
    end
  end

  assign ifid_instr   = ifid_instr_q;
  assign ifid_pc_plus = ifid_pc_plus_q;
  assign ifid_valid   = ifid_valid_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: external PC register, behavioural fetch model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pc_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] pc_reg = 16'h0000;
  logic [15:0] pc_d;
  logic        pc_we;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] ifid_instr;
  logic [15:0] ifid_pc_plus;
  logic        ifid_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  pc_fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .pc_q         (pc_reg),
    .pc_d         (pc_d),
    .pc_we        (pc_we),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .stall        (stall),
    .br_taken     (br_taken),
    .br_target    (br_target),
    .ifid_instr   (ifid_instr),
    .ifid_pc_plus (ifid_pc_plus),
    .ifid_valid   (ifid_valid),
    .halted       (halted)
  );

  always #5 clk = ~clk;

  // The PC register this controller sits in front of.
  always @(posedge clk) if (pc_we) pc_reg <= pc_d;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the fetch unit is either loading the reset PC,
  // running (misses and stalls just decide whether IF/ID gets a bubble or holds),
  // or halted.
  localparam int M_LOAD = 0, M_RUN = 1, M_HALTED = 2;
  int          m_mode    = M_LOAD;
  bit          m_started = 0;
  logic [15:0] m_instr   = '0;
  logic [15:0] m_pcp     = '0;
  logic        m_valid   = 1'b0;

  always @(posedge clk) begin
    logic [15:0] nxt;
    nxt = pc_reg + 16'd2;
    if (!rst) begin
      m_started = 1;
      m_mode    = M_LOAD;
      m_instr   = '0;
      m_pcp     = '0;
      m_valid   = 1'b0;
    end else if (m_started) begin
      if (m_mode == M_LOAD) begin
        m_mode = M_RUN;
      end else if (m_mode == M_RUN) begin
        if (br_taken) m_valid = 1'b0;
        else if (stall) begin end
        else if (!imem_ready) m_valid = 1'b0;
        else begin
          m_instr = imem_rdata;
          m_pcp   = nxt;
          m_valid = 1'b1;
          if (imem_rdata[15:12] == 4'hF) m_mode = M_HALTED;
        end
      end else begin
        if (br_taken) begin
          m_valid = 1'b0;
          m_mode  = M_RUN;
        end else if (!stall) m_valid = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    logic        e_we, e_req;
    logic [15:0] e_d;
    if (m_started) begin
      e_we = 1'b0; e_req = 1'b0; e_d = 16'h0000;
      if (rst) begin
        if (m_mode == M_LOAD) begin
          e_we = 1'b1; e_d = 16'h0000;
        end else if (br_taken) begin
          e_we = 1'b1; e_d = br_target; e_req = (m_mode == M_RUN);
        end else if (m_mode == M_RUN) begin
          e_req = 1'b1;
          if (!stall && imem_ready && imem_rdata[15:12] != 4'hF) begin
            e_we = 1'b1; e_d = pc_reg + 16'd2;
          end
        end
      end
      chk("pc_we", pc_we, e_we);
      chk("imem_req", imem_req, e_req);
      if (e_we || !rst) chk("pc_d", pc_d, e_d);
      chk("imem_addr", imem_addr, pc_reg);
      chk("ifid_valid", ifid_valid, m_valid);
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pc_plus", ifid_pc_plus, m_pcp);
      chk("halted", halted, m_mode == M_HALTED);
    end
  end

  // One cycle of stimulus; returns just after the negedge compare.
  task automatic cyc(input logic r, input logic rdy, input logic [15:0] rd,
                     input logic st, input logic b, input logic [15:0] t);
    @(posedge clk);
    #1;
    rst = r; imem_ready = rdy; imem_rdata = rd; stall = st; br_taken = b; br_target = t;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; imem_ready = 1'b0; imem_rdata = '0; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    repeat (3) cyc(0, 0, 16'h0, 0, 0, 16'h0);
    chk("rst_pc_we", pc_we, 1'b0);
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_valid", ifid_valid, 1'b0);

    // reset load, then four hits
    cyc(1, 0, 16'h0, 0, 0, 16'h0);
    chk("load_we", pc_we, 1'b1);
    chk("load_pc_d", pc_d, 16'h0000);
    chk("load_req", imem_req, 1'b0);
    cyc(1, 1, 16'h1000, 0, 0, 16'h0);
    chk("hit1_pc_d", pc_d, 16'h0002);
    cyc(1, 1, 16'h2000, 0, 0, 16'h0);
    chk("hit1_instr", ifid_instr, 16'h1000);
    chk("hit1_pcp", ifid_pc_plus, 16'h0002);
    chk("hit2_pc_d", pc_d, 16'h0004);
    cyc(1, 1, 16'h3000, 0, 0, 16'h0);
    chk("hit2_instr", ifid_instr, 16'h2000);
    chk("hit2_pcp", ifid_pc_plus, 16'h0004);
    cyc(1, 1, 16'h4000, 0, 0, 16'h0);
    chk("hit3_pcp", ifid_pc_plus, 16'h0006);
    cyc(1, 0, 16'h0, 1, 0, 16'h0);
    chk("hit4_instr", ifid_instr, 16'h4000);
    chk("hit4_pcp", ifid_pc_plus, 16'h0008);
    chk("hit4_valid", ifid_valid, 1'b1);
    chk("hit4_pc", pc_reg, 16'h0008);

    // miss: three wait cycles at 0x0010
    cyc(1, 1, 16'h0, 0, 1, 16'h0010);
    cyc(1, 0, 16'h0, 0, 0, 16'h0);
    chk("miss_pc", pc_reg, 16'h0010);
    chk("miss_flush", ifid_valid, 1'b0);
    cyc(1, 0, 16'h0, 0, 0, 16'h0);
    cyc(1, 0, 16'h0, 0, 0, 16'h0);
    cyc(1, 1, 16'h5000, 0, 0, 16'h0);
    chk("miss_bubble", ifid_valid, 1'b0);
    chk("miss_pc_d", pc_d, 16'h0012);
    cyc(1, 0, 16'h0, 1, 0, 16'h0);
    chk("miss_pcp", ifid_pc_plus, 16'h0012);
    chk("miss_pc_after", pc_reg, 16'h0012);

    // branch beats stall, then a 5-cycle stall
    cyc(1, 1, 16'h0, 1, 1, 16'h0040);
    cyc(1, 1, 16'h6000, 0, 0, 16'h0);
    chk("brst_pc", pc_reg, 16'h0040);
    chk("brst_valid", ifid_valid, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, i[0], 16'h9999, 1, 0, 16'h0);
      chk("stall_instr", ifid_instr, 16'h6000);
      chk("stall_pc", pc_reg, 16'h0042);
      chk("stall_we", pc_we, 1'b0);
    end

    // HALT and wrong-path recovery
    cyc(1, 1, 16'h0, 0, 1, 16'h0020);
    cyc(1, 1, 16'hF000, 0, 0, 16'h0);
    chk("halt_we", pc_we, 1'b0);
    cyc(1, 1, 16'h1111, 1, 0, 16'h0);
    chk("halt_flag", halted, 1'b1);
    chk("halt_instr", ifid_instr, 16'hF000);
    chk("halt_pcp", ifid_pc_plus, 16'h0022);
    chk("halt_pc", pc_reg, 16'h0020);
    chk("halt_req", imem_req, 1'b0);
    cyc(1, 1, 16'h0, 0, 1, 16'h0100);
    cyc(1, 0, 16'h0, 0, 0, 16'h0);
    chk("unhalt_flag", halted, 1'b0);
    chk("unhalt_valid", ifid_valid, 1'b0);
    chk("unhalt_pc", pc_reg, 16'h0100);
    chk("unhalt_req", imem_req, 1'b1);

    // wrap at top of address space
    cyc(1, 1, 16'h0, 0, 1, 16'hFFFE);
    cyc(1, 1, 16'h7000, 0, 0, 16'h0);
    chk("wrap_pc_d", pc_d, 16'h0000);
    chk("wrap_we", pc_we, 1'b1);
    cyc(1, 0, 16'h0, 1, 0, 16'h0);
    chk("wrap_pcp", ifid_pc_plus, 16'h0000);
    chk("wrap_pc", pc_reg, 16'h0000);

    // reset during a miss
    cyc(1, 0, 16'h0, 0, 1, 16'h0030);
    cyc(1, 0, 16'h0, 0, 0, 16'h0);
    cyc(1, 0, 16'h0, 0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 0, 16'h0);
    chk("mrst_we", pc_we, 1'b0);
    chk("mrst_pc_d", pc_d, 16'h0000);
    cyc(1, 0, 16'h0, 0, 0, 16'h0);
    chk("mrst_valid", ifid_valid, 1'b0);
    chk("mrst_halted", halted, 1'b0);
    chk("mrst_load_we", pc_we, 1'b1);
    chk("mrst_load_d", pc_d, 16'h0000);
    cyc(1, 1, 16'h1234, 0, 0, 16'h0);
    chk("mrst_pc", pc_reg, 16'h0000);
    chk("mrst_req", imem_req, 1'b1);

    // randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      logic r, rdy, st, b;
      logic [15:0] rd, t;
      r   = ($urandom_range(0, 99) != 0);
      rdy = ($urandom_range(0, 9) < 7);
      st  = ($urandom_range(0, 4) == 0);
      b   = ($urandom_range(0, 9) == 0);
      rd  = 16'($urandom);
      t   = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom);
      cyc(r, rdy, rd, st, b, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
